transposer_wr_drain: RTL and testbench
======================================

# transposer_wr_drain

Write-side drain stage directly downstream of the transposer. It captures every `waddr`/`wdata` beat the transposer emits, which that block never stalls, into a small FIFO. It replays the beats to the output-buffer write port under a valid/ready handshake and raises `done` once the transposer's `finish` has been seen and every queued beat has been accepted. It also counts committed writes and flags any beat lost to FIFO overflow.

## Interface
- `AW`, 16, address width (matches transposer `waddr`)
- `BUFFD`, 64, data width in bytes; data bus is `BUFFD*8` bits
- `FD`, 4, FIFO depth in entries; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `init_pulse`  in  1  one-cycle start of a new job (same pulse given to the transposer)
- `waddr`  in  AW  write address from transposer
- `wdata`  in  BUFFD*8  write data from transposer
- `wdata_vld`  in  1  beat valid from transposer; no backpressure path exists
- `finish`  in  1  one-cycle pulse from transposer after, or with, its last beat
- `mem_waddr`  out  AW  output-buffer write address
- `mem_wdata`  out  BUFFD*8  output-buffer write data
- `mem_wvld`  out  1  write request valid
- `mem_wrdy`  in  1  write port ready; a beat transfers when `mem_wvld & mem_wrdy`
- `done`  out  1  level; job complete, held until the next `init_pulse`
- `overflow`  out  1  sticky; a beat was dropped because the FIFO was full
- `wr_cnt`  out  AW  number of completed memory writes this job
- `level`  out  $clog2(FD)+1  current FIFO occupancy

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Any state + `init_pulse` → RUN. On that edge: clear FIFO pointers, `wr_cnt`, `overflow` and `done`. `init_pulse` has priority over every other event in the same cycle.
- RUN + `finish` → DRAIN.
- DRAIN with FIFO empty (`level==0`) → DONE. If `finish` arrives while already empty in RUN, DONE is entered one cycle after DRAIN.
- DONE: `done=1`. Remains until `init_pulse`.
- Push: `wdata_vld` in RUN or DRAIN writes {`waddr`,`wdata`} to the tail. A beat arriving together with `finish` is pushed.
- `wdata_vld` in IDLE or DONE is ignored. No push, no flag.
- Pop: head is presented first-word-fall-through. `mem_wvld = (level!=0)`. On `mem_wvld & mem_wrdy` the head is popped and `wr_cnt` increments, wrapping modulo 2^AW.
- Full case: push while `level==FD` with no pop in the same cycle drops the incoming beat and sets `overflow`. Push while full with a pop in the same cycle is accepted, and `level` stays FD.
- Simultaneous push and pop at any level leaves `level` unchanged and preserves FIFO order.
- `init_pulse` mid-job discards queued beats. `mem_wvld` is low on the following cycle, and the in-flight head is not counted.
- `mem_waddr`/`mem_wdata` are don't-care when `mem_wvld=0`. They are driven from FIFO storage, not from the inputs.

## Timing
- Reset (async assert): `mem_wvld=0`, `done=0`, `overflow=0`, `wr_cnt=0`, `level=0`, `mem_waddr=0`, `mem_wdata=0`, state IDLE.
- Push latency: a beat pushed at edge N appears on `mem_*` with `mem_wvld=1` after edge N, i.e. one cycle.
- Throughput: one beat per cycle when `mem_wrdy` is held high; the FIFO never exceeds 1 entry in that case.
- `done` rises one cycle after the edge at which the last pop empties the FIFO in DRAIN.
- `wr_cnt`, `level` and `overflow` update on the edge of the causing event and are registered outputs.
- `mem_wvld` never depends combinationally on `mem_wrdy`.

## Test plan
- Basic: init, 8 beats at addr 0x10..0x17 with `mem_wrdy=1`, then `finish` → 8 writes in order, each 1 cycle after input; `wr_cnt=8`; `done=1`; `overflow=0`.
- Backpressure: FD=4, `mem_wrdy=0`, push 4 beats → `level=4`, `mem_wvld=1`, head addr is the first beat. Raise ready → 4 ordered writes, then `done` after `finish`.
- Overflow: FD=4, ready low, 5 beats → 5th dropped, `overflow=1`, `wr_cnt=4` after drain. Repeat with a pop on the 5th cycle → no drop.
- Finish with last beat: `finish` and `wdata_vld` in the same cycle → beat written; `done` only after it is accepted.
- Mid-job init: 3 beats queued with ready low, then `init_pulse` → `level=0`, `mem_wvld=0` next cycle, `wr_cnt=0`, state RUN. New job completes normally.
- Async reset asserted during DRAIN with 2 beats queued → all outputs zero immediately. Beats arriving before `init_pulse` are ignored.

Source files
------------

// File: rtl/transposer_wr_drain.sv
// Write-side drain stage behind the transposer: buffers every write beat in a small FIFO
// and replays the beats to the output-buffer write port under a valid/ready handshake.
module transposer_wr_drain #(
  parameter int AW    = 16,
  parameter int BUFFD = 64,
  parameter int FD    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   init_pulse,
  input  logic [AW-1:0]          waddr,
  input  logic [BUFFD*8-1:0]     wdata,
  input  logic                   wdata_vld,
  input  logic                   finish,
  output logic [AW-1:0]          mem_waddr,
  output logic [BUFFD*8-1:0]     mem_wdata,
  output logic                   mem_wvld,
  input  logic                   mem_wrdy,
  output logic                   done,
  output logic                   overflow,
  output logic [AW-1:0]          wr_cnt,
  output logic [$clog2(FD):0]    level
);

  localparam int PW = $clog2(FD);
  localparam int LW = PW + 1;
  localparam int DW = BUFFD * 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] addr_mem [FD];
  logic [DW-1:0] data_mem [FD];

  logic full;
  logic empty;
  logic push_req;
  logic push_acc;
  logic pop;

  assign full  = (level == LW'(FD));
  assign empty = (level == '0);

  // Valid comes only from registered occupancy, so it never depends on mem_wrdy.
  assign mem_wvld = !empty;
  assign pop      = mem_wvld && mem_wrdy && !init_pulse;
  assign push_req = wdata_vld && ((state == RUN) || (state == DRAIN)) && !init_pulse;
  // A full FIFO still takes a beat when the head leaves in the same cycle.
  assign push_acc = push_req && (!full || pop);

  // Storage is gated to zero while empty so outputs are clean out of reset.
  assign mem_waddr = mem_wvld ? addr_mem[rd_ptr] : '0;
  assign mem_wdata = mem_wvld ? data_mem[rd_ptr] : '0;

  // NOTE: FIFO storage has no reset; entries are only read after being written,
  // and leaving it unreset keeps the wide data array out of the reset tree.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      addr_mem[wr_ptr] <= waddr;
      data_mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else if (init_pulse) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wr_cnt <= wr_cnt + AW'(1);
      end

      if (push_acc && !pop)      level <= level + LW'(1);
      else if (!push_acc && pop) level <= level - LW'(1);

      if (push_req && !push_acc) overflow <= 1'b1;

      case (state)
        RUN: if (finish) state <= DRAIN;
        DRAIN: begin
          // A beat landing this very cycle still has to drain before completion.
          if (empty && !push_acc) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_transposer_wr_drain.sv
// Scoreboard bench for transposer_wr_drain: a reference model predicts FIFO contents,
// counters and flags each cycle; accepted writes are popped from the queue and compared.
module tb_transposer_wr_drain;

  localparam int AW    = 16;
  localparam int BUFFD = 64;
  localparam int FD    = 4;
  localparam int DW    = BUFFD * 8;
  localparam int LW    = $clog2(FD) + 1;
  localparam int W     = AW + DW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              init_pulse;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              wdata_vld;
  logic              finish;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_wvld;
  logic              mem_wrdy;
  logic              done;
  logic              overflow;
  logic [AW-1:0]     wr_cnt;
  logic [LW-1:0]     level;

  transposer_wr_drain #(.AW(AW), .BUFFD(BUFFD), .FD(FD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .init_pulse (init_pulse),
    .waddr      (waddr),
    .wdata      (wdata),
    .wdata_vld  (wdata_vld),
    .finish     (finish),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wvld   (mem_wvld),
    .mem_wrdy   (mem_wrdy),
    .done       (done),
    .overflow   (overflow),
    .wr_cnt     (wr_cnt),
    .level      (level)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} m_state_t;

  logic [W-1:0]  sb[$];
  m_state_t      m_state;
  logic [AW-1:0] m_cnt;
  logic          m_ovf;
  logic          m_done;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input m_state_t s);
    sb.delete();
    m_state = s;
    m_cnt   = '0;
    m_ovf   = 1'b0;
    m_done  = 1'b0;
  endtask

  // Called at posedge+1: drive one cycle of inputs, check at negedge, advance the model.
  task automatic step(input logic i_init, input logic i_vld, input logic i_fin,
                      input logic i_rdy, input logic [AW-1:0] a);
    logic [DW-1:0] d;
    logic          m_pop;
    logic          pushed;
    int            lvl;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    init_pulse = i_init;
    wdata_vld  = i_vld;
    finish     = i_fin;
    mem_wrdy   = i_rdy;
    waddr      = a;
    wdata      = d;
    @(negedge clk);
    lvl = sb.size();
    check("wvld",  W'(mem_wvld), W'(lvl != 0));
    check("level", W'(level),    W'(lvl));
    check("wrcnt", W'(wr_cnt),   W'(m_cnt));
    check("ovf",   W'(overflow), W'(m_ovf));
    check("done",  W'(done),     W'(m_done));
    if (lvl != 0 && mem_wvld && mem_wrdy) check("head", {mem_waddr, mem_wdata}, sb[0]);

    m_pop = (lvl != 0) && i_rdy && !i_init;
    if (i_init) begin
      model_clear(M_RUN);
    end else begin
      pushed = 1'b0;
      if (m_pop) begin
        void'(sb.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (i_vld && (m_state == M_RUN || m_state == M_DRAIN)) begin
        if (lvl < FD || m_pop) begin
          sb.push_back({a, d});
          pushed = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      case (m_state)
        M_RUN:   if (i_fin) m_state = M_DRAIN;
        M_DRAIN: if (lvl == 0 && !pushed) begin
          m_state = M_DONE;
          m_done  = 1'b1;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_job(input int max_cycles);
    int n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      n++;
    end
    check("drain_done", W'(done), W'(1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wvld"},  W'(mem_wvld),  '0);
    check({tag, "_done"},  W'(done),      '0);
    check({tag, "_ovf"},   W'(overflow),  '0);
    check({tag, "_wrcnt"}, W'(wr_cnt),    '0);
    check({tag, "_level"}, W'(level),     '0);
    check({tag, "_addr"},  W'(mem_waddr), '0);
    check({tag, "_data"},  W'(mem_wdata), '0);
  endtask

  initial begin
    reset_n    = 1'b0;
    init_pulse = 1'b0;
    wdata_vld  = 1'b0;
    finish     = 1'b0;
    mem_wrdy   = 1'b0;
    waddr      = '0;
    wdata      = '0;
    model_clear(M_IDLE);
    #2;
    check_zero_outputs("rst");
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: 8 beats with ready held high, then finish.
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1, AW'(16'h10 + i));
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    drain_job(20);
    check("basic_cnt", W'(wr_cnt),   W'(8));
    check("basic_ovf", W'(overflow), W'(0));

    // Backpressure: fill to FD with ready low, then release.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, AW'(16'h20 + i));
    check("bp_level", W'(level),     W'(4));
    check("bp_wvld",  W'(mem_wvld),  W'(1));
    check("bp_head",  W'(mem_waddr), W'(16'h20));
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    drain_job(20);
    check("bp_cnt", W'(wr_cnt), W'(4));

    // Overflow: fifth beat into a full FIFO with no pop is dropped.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, AW'(16'h30 + i));
    check("ovf_set", W'(overflow), W'(1));
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    drain_job(20);
    check("ovf_cnt", W'(wr_cnt), W'(4));

    // Same, but a pop on the fifth cycle makes room: nothing dropped.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, AW'(16'h40 + i));
    step(1'b0, 1'b1, 1'b0, 1'b1, AW'(16'h44));
    check("nodrop_level", W'(level), W'(4));
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    drain_job(20);
    check("nodrop_ovf", W'(overflow), W'(0));
    check("nodrop_cnt", W'(wr_cnt),   W'(5));

    // Finish together with the last beat; ready held low so done must wait.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, AW'(16'h50));
    step(1'b0, 1'b1, 1'b1, 1'b0, AW'(16'h51));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("fin_notdone", W'(done), W'(0));
    drain_job(20);
    check("fin_cnt", W'(wr_cnt), W'(2));

    // Mid-job init discards queued beats.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, AW'(16'h60 + i));
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("mid_level", W'(level),    W'(0));
    check("mid_wvld",  W'(mem_wvld), W'(0));
    check("mid_cnt",   W'(wr_cnt),   W'(0));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1, AW'(16'h70 + i));
    step(1'b0, 1'b0, 1'b1, 1'b1, '0);
    drain_job(20);
    check("mid_newcnt", W'(wr_cnt), W'(2));

    // Async reset while in DRAIN with two beats queued.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, AW'(16'h80 + i));
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    init_pulse = 1'b0;
    wdata_vld  = 1'b0;
    finish     = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("arst");
    model_clear(M_IDLE);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, AW'(16'h90 + i));
    check("idle_ignored", W'(wr_cnt), W'(0));

    // Random traffic with occasional backpressure and overflow.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 2) != 0), AW'(16'hA00 + i));
    step(1'b0, 1'b1, 1'b1, 1'b0, AW'(16'hAFF));
    drain_job(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
